// File: rtl/wave_scheduler.sv
// wave_scheduler: programmable step sequencer for the audio tone path.
//
// A DEPTH-entry table of {wave_sel, amp, freq_sel, dur} steps is played back
// one step at a time, each step lasting dur codec samples. Every output change
// lands on a sample boundary because step ends are triggered by sample_req.
//
// Optional feature: define WAVE_SCHED_GAP_EN to insert a one-sample muted gap
// between consecutive steps (never after the final step of a program).
module wave_scheduler #(
  parameter int DEPTH = 16,
  parameter int DUR_W = 12,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int ENT_W = 8 + DUR_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sample_req,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  input  logic             prog_we,
  input  logic [IDX_W-1:0] prog_addr,
  input  logic [ENT_W-1:0] prog_data,
  output logic [2:0]       wave_sel,
  output logic [2:0]       amp_ctrl,
  output logic [1:0]       freq_sel,
  output logic             mute,
  output logic             busy,
  output logic [IDX_W-1:0] step_idx,
  output logic             done
);

  // One program step, laid out exactly as it arrives on prog_data.
  typedef struct packed {
    logic [2:0]       wave;
    logic [2:0]       amp;
    logic [1:0]       freq;
    logic [DUR_W-1:0] dur;
  } entry_t;

`ifdef WAVE_SCHED_GAP_EN
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_e;
`endif

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [DUR_W-1:0] CNT_ONE  = DUR_W'(1);

  entry_t           mem_q [DEPTH];

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [DUR_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       wave_q,  wave_d;
  logic [2:0]       amp_q,   amp_d;
  logic [1:0]       freq_q,  freq_d;
  logic             mute_q,  mute_d;
  logic             done_q,  done_d;

  entry_t           cur_entry;
  logic [IDX_W-1:0] next_idx;
  logic             go_idle;

`ifdef WAVE_SCHED_GAP_EN
  // The entry after the one now playing, used to tell whether the step that
  // is ending is the last audible one (no gap before the program ends).
  entry_t           peek_entry;
  logic             next_ends;
`endif

  // Program table: written by prog_we, read combinationally at LOAD.
  // NOTE: the table is deliberately left out of reset; its contents must
  // survive reset_n, and a reset-free memory maps onto plain RAM/registers.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem_q[prog_addr] <= entry_t'(prog_data);
    end
  end

  // Next-state and output-register logic for the step sequencer.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    wave_d    = wave_q;
    amp_d     = amp_q;
    freq_d    = freq_q;
    mute_d    = mute_q;
    done_d    = 1'b0;
    go_idle   = 1'b0;
    cur_entry = mem_q[idx_q];
    next_idx  = idx_q + 1'b1;   // wraps modulo DEPTH by width
`ifdef WAVE_SCHED_GAP_EN
    peek_entry = mem_q[next_idx];
    next_ends  = (peek_entry.dur == '0) && !(loop_en && (next_idx != '0));
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (cur_entry.dur == '0) begin
          // End marker: wrap to entry 0 when looping, otherwise finish.
          if ((idx_q != '0) && loop_en) begin
            idx_d = '0;
          end else begin
            done_d  = 1'b1;
            go_idle = 1'b1;
          end
        end else begin
          wave_d  = cur_entry.wave;
          amp_d   = cur_entry.amp;
          freq_d  = cur_entry.freq;
          mute_d  = 1'b0;
          cnt_d   = cur_entry.dur;
          state_d = S_PLAY;
        end
      end

      S_PLAY: begin
        if (sample_req) begin
          if (cnt_q == CNT_ONE) begin
            if ((idx_q == LAST_IDX) && !loop_en) begin
              done_d  = 1'b1;
              go_idle = 1'b1;
            end else begin
              idx_d   = next_idx;
              state_d = S_LOAD;
`ifdef WAVE_SCHED_GAP_EN
              if (!next_ends) begin
                state_d = S_GAP;
                mute_d  = 1'b1;
              end
`endif
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end

`ifdef WAVE_SCHED_GAP_EN
      S_GAP: begin
        // Hold the previous tone settings silenced for one sample.
        if (sample_req) begin
          state_d = S_LOAD;
        end
      end
`endif

      default: begin
        go_idle = 1'b1;
      end
    endcase

    // stop overrides everything, including a same-cycle natural end.
    if (stop) begin
      go_idle = 1'b1;
      done_d  = 1'b0;
    end

    if (go_idle) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      wave_d  = '0;
      amp_d   = '0;
      freq_d  = '0;
      mute_d  = 1'b1;
    end
  end

  // State and output registers; reset forces the silent IDLE values at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      wave_q  <= '0;
      amp_q   <= '0;
      freq_q  <= '0;
      mute_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wave_q  <= wave_d;
      amp_q   <= amp_d;
      freq_q  <= freq_d;
      mute_q  <= mute_d;
      done_q  <= done_d;
    end
  end

  assign wave_sel = wave_q;
  assign amp_ctrl = amp_q;
  assign freq_sel = freq_q;
  assign mute     = mute_q;
  assign busy     = (state_q != S_IDLE);
  assign step_idx = idx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_wave_scheduler.sv
// tb_wave_scheduler: scoreboard bench for wave_scheduler.
// A step-level reference model turns each playback run into a per-cycle list
// of expected outputs; a separate monitor pops and compares them.
`timescale 1ns/1ps
module tb_wave_scheduler;
  localparam int DEPTH = 16;
  localparam int DUR_W = 12;
  localparam int IW    = 4;
  localparam int EW    = 8 + DUR_W;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sample_req = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop_en = 1'b0;
  logic          prog_we = 1'b0;
  logic [IW-1:0] prog_addr = '0;
  logic [EW-1:0] prog_data = '0;
  logic [2:0]    wave_sel, amp_ctrl;
  logic [1:0]    freq_sel;
  logic          mute, busy, done;
  logic [IW-1:0] step_idx;

  wave_scheduler #(.DEPTH(DEPTH), .DUR_W(DUR_W)) dut (
    .clk(clk), .reset_n(reset_n), .sample_req(sample_req), .start(start),
    .stop(stop), .loop_en(loop_en), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .wave_sel(wave_sel), .amp_ctrl(amp_ctrl),
    .freq_sel(freq_sel), .mute(mute), .busy(busy), .step_idx(step_idx),
    .done(done)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; "cycle c" is the period after edge c.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [2:0]    wave, amp;
    logic [1:0]    freq;
    logic          mute;
    logic [IW-1:0] idx;
    logic          busy, done;
  } exp_t;

  typedef struct {
    int            cyc;
    int            addr;
    logic [EW-1:0] data;
  } wr_t;

  exp_t sb[$];
  wr_t  wlog[$];
  int   per = 8, ph = 3;
  int   vectors = 0, miscompares = 0;
  bit   all_done = 1'b0;

  // ---------------- reference model ----------------
  function automatic bit sreq_at(int c);
    return (c % per) == ph;
  endfunction

  // Table contents as seen during cycle c (a write in cycle w is visible from w+1).
  function automatic logic [EW-1:0] table_at(int a, int c);
    logic [EW-1:0] d = '0;
    foreach (wlog[i]) if (wlog[i].addr == a && wlog[i].cyc < c) d = wlog[i].data;
    return d;
  endfunction

  function automatic void push(int c, logic [2:0] w, logic [2:0] a, logic [1:0] f,
                               logic m, int idx, logic b, logic dn);
    exp_t e;
    e.cyc = c; e.wave = w; e.amp = a; e.freq = f; e.mute = m;
    e.idx = IW'(idx); e.busy = b; e.done = dn;
    sb.push_back(e);
  endfunction

  function automatic void push_idle(int c, logic dn);
    push(c, 3'd0, 3'd0, 2'd0, 1'b1, 0, 1'b0, dn);
    push(c + 1, 3'd0, 3'd0, 2'd0, 1'b1, 0, 1'b0, 1'b0);
  endfunction

  // Walk the program step by step from a start in cycle t0; returns the last
  // cycle for which an expectation was queued.
  function automatic int build(int t0, bit lp, int stop_c);
    int            c = t0 + 1;
    int            idx = 0;
    int            n;
    int            dur;
    logic [EW-1:0] d;
    logic [2:0]    w = 3'd0, a = 3'd0;
    logic [1:0]    f = 2'd0;
    logic          m = 1'b1;
    while (c < t0 + 50000) begin
      if (c > stop_c) begin push_idle(c, 1'b0); return c + 1; end
      push(c, w, a, f, m, idx, 1'b1, 1'b0);            // LOAD cycle
      d   = table_at(idx, c);
      dur = int'(d[DUR_W-1:0]);
      if (dur == 0) begin
        if (idx != 0 && lp) begin idx = 0; c++; continue; end
        push_idle(c + 1, (c + 1) <= stop_c);
        return c + 2;
      end
      w = d[19:17]; a = d[16:14]; f = d[13:12]; m = 1'b0;
      n = 0;
      c++;
      while (1) begin                                  // step plays for dur pulses
        if (c > stop_c) begin push_idle(c, 1'b0); return c + 1; end
        push(c, w, a, f, m, idx, 1'b1, 1'b0);
        if (sreq_at(c)) begin n++; if (n == dur) break; end
        c++;
      end
      if (idx == DEPTH - 1 && !lp) begin push_idle(c + 1, (c + 1) <= stop_c); return c + 2; end
      idx = (idx + 1) % DEPTH;
      c++;
`ifdef WAVE_SCHED_GAP_EN
      d = table_at(idx, c - 1);
      if (!((d[DUR_W-1:0] == '0) && !(lp && idx != 0))) begin
        m = 1'b1;
        while (1) begin                                // silent gap up to next pulse
          if (c > stop_c) begin push_idle(c, 1'b0); return c + 1; end
          push(c, w, a, f, m, idx, 1'b1, 1'b0);
          if (sreq_at(c)) break;
          c++;
        end
        c++;
      end
`endif
    end
    return c;
  endfunction

  // ---------------- monitor ----------------
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    while (1) begin
      @(negedge clk or negedge reset_n or posedge all_done);
      if (all_done) break;
      if (!reset_n && clk) begin
        #1;
        check("rst_wave", 32'(wave_sel), 0);
        check("rst_amp",  32'(amp_ctrl), 0);
        check("rst_freq", 32'(freq_sel), 0);
        check("rst_mute", 32'(mute), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_idx",  32'(step_idx), 0);
        check("rst_done", 32'(done), 0);
      end else if (!clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
          e = sb.pop_front();
          check("stale_expectation", 32'(e.cyc), 32'(cyc));
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
          e = sb.pop_front();
          check("wave_sel", 32'(wave_sel), 32'(e.wave));
          check("amp_ctrl", 32'(amp_ctrl), 32'(e.amp));
          check("freq_sel", 32'(freq_sel), 32'(e.freq));
          check("mute",     32'(mute),     32'(e.mute));
          check("step_idx", 32'(step_idx), 32'(e.idx));
          check("busy",     32'(busy),     32'(e.busy));
          check("done",     32'(done),     32'(e.done));
        end
      end
    end
    check("leftover_expectations", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  task automatic write_entry(int addr, logic [2:0] w, logic [2:0] a, logic [1:0] f, int dur);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = IW'(addr); prog_data = {w, a, f, DUR_W'(dur)};
    wlog.push_back('{cyc, addr, prog_data});
  endtask

  task automatic end_writes();
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // One playback run; optional stop and mid-run table write, relative to start.
  task automatic run(bit lp, int stop_after, int wr_after, int wr_addr,
                     logic [EW-1:0] wr_data, bit spur);
    int t0, stop_c, end_c, wr_c;
    @(negedge clk);
    t0     = cyc;
    stop_c = (stop_after > 0) ? t0 + stop_after : 32'h3fff_ffff;
    wr_c   = (wr_after > 0) ? t0 + wr_after : -1;
    if (wr_c > 0) wlog.push_back('{wr_c, wr_addr, wr_data});
    loop_en = lp; start = 1'b1; stop = 1'b0; sample_req = sreq_at(t0);
    end_c = build(t0, lp, stop_c);
    for (int c = t0 + 1; c <= end_c; c++) begin
      @(negedge clk);
      start      = spur && (c <= end_c - 2) && ($urandom_range(0, 5) == 0);
      stop       = (c == stop_c);
      sample_req = sreq_at(c);
      prog_we    = (c == wr_c);
      prog_addr  = IW'(wr_addr);
      prog_data  = wr_data;
    end
    start = 1'b0; stop = 1'b0; prog_we = 1'b0;
  endtask

  initial begin : stimulus
    int t0, tmp;
    push_idle(1, 1'b0);                        // outputs while reset is held
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Test-plan program: {3,5,2} then end marker; remaining entries random.
    write_entry(0, 3'd1, 3'd2, 2'd1, 3);
    write_entry(1, 3'd2, 3'd5, 2'd2, 5);
    write_entry(2, 3'd4, 3'd7, 2'd3, 2);
    write_entry(3, 3'd0, 3'd0, 2'd0, 0);
    for (int i = 4; i < DEPTH; i++)
      write_entry(i, 3'($urandom), 3'($urandom), 2'($urandom), $urandom_range(1, 4));
    end_writes();

    per = 8; ph = 3;
    run(1'b0, 0, 0, 0, '0, 1'b0);              // single pass, ends with done
    run(1'b1, 110, 0, 0, '0, 1'b0);            // looping, stopped later
    run(1'b0, 38, 0, 0, '0, 1'b0);             // stop inside entry 1
    run(1'b0, 0, 0, 0, '0, 1'b1);              // restart from entry 0
    run(1'b1, 150, 38, 1, {3'd2, 3'd5, 2'd2, 12'd2}, 1'b0); // rewrite active entry 1

    // Reset mid-step, then replay the retained table.
    @(negedge clk);
    t0 = cyc; loop_en = 1'b0; start = 1'b1; sample_req = sreq_at(t0);
    tmp = build(t0, 1'b0, t0 + 12);
    for (int c = t0 + 1; c <= t0 + 12; c++) begin
      @(negedge clk);
      start = 1'b0; sample_req = sreq_at(c);
    end
    @(posedge clk);
    #2;
    sb.delete();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run(1'b0, 0, 0, 0, '0, 1'b0);

    // Randomized programs, pulse rates, loop settings and stops.
    for (int r = 0; r < 14; r++) begin
      for (int i = 0; i < DEPTH; i++)
        if ($urandom_range(0, 1) == 0)
          write_entry(i, 3'($urandom), 3'($urandom), 2'($urandom),
                      ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6));
      end_writes();
      per = $urandom_range(1, 6);
      ph  = $urandom_range(0, per - 1);
      if ($urandom_range(0, 1) == 1)
        run(1'b1, $urandom_range(10, 160), 0, 0, '0, 1'b1);
      else
        run(1'b0, ($urandom_range(0, 3) == 0) ? $urandom_range(2, 60) : 0, 0, 0, '0, 1'b1);
    end

    repeat (3) @(negedge clk);
    all_done = 1'b1;
  end

endmodule

// File: doc/wave_scheduler.md
# wave_scheduler

Programmable step sequencer for the audio tone path. Holds a small table of steps (waveform, amplitude code, frequency select, duration in samples) and drives the waveform-select, amplitude-control and frequency-select lines that the top level currently takes from switches. All changes happen on sample boundaries, so a waveform never switches mid-sample. It runs in the audio clock domain, alongside the audio codec, and paces itself from the codec's right-channel `sample_req` strobe.

## Interface
- `DEPTH`, 16: number of step entries; must be a power of two, 2..256.
- `DUR_W`, 12: width of the per-step duration field, in samples.
- `clk` input 1: audio clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `sample_req` input 1: one-cycle pulse per output sample, from the codec.
- `start` input 1: one-cycle pulse; begins playback at entry 0.
- `stop` input 1: one-cycle pulse; aborts playback.
- `loop_en` input 1: restart at entry 0 when the end of the program is reached.
- `prog_we` input 1: table write strobe.
- `prog_addr` input log2(DEPTH): table write address.
- `prog_data` input 8+DUR_W: {wave_sel[2:0], amp[2:0], freq_sel[1:0], dur[DUR_W-1:0]}.
- `wave_sel` output 3: same encoding as the top-level SW[3:1] waveform select.
- `amp_ctrl` output 3: amplitude code; same encoding as SW[8:6].
- `freq_sel` output 2: PLL frequency select; same encoding as SW[5:4].
- `mute` output 1: high when no tone should be heard.
- `busy` output 1: high in any state other than IDLE.
- `step_idx` output log2(DEPTH): index of the active entry.
- `done` output 1: one-cycle pulse when the program ends naturally.

## Operation
- Table: DEPTH x (8+DUR_W) registers, not reset.
  - A write is visible the cycle after `prog_we`.
  - A write to the active entry takes effect only at that entry's next LOAD.
- States are IDLE, LOAD, PLAY and GAP (GAP exists only under the configuration macro).
- IDLE: on `start`, set idx=0 and go to LOAD. `start` is ignored in every other state.
- LOAD (one cycle): read entry[idx].
  - dur==0 is an end marker: if idx!=0 and `loop_en`=1, set idx=0 and stay in LOAD; otherwise pulse `done` and go to IDLE.
  - dur!=0: register wave_sel/amp_ctrl/freq_sel from the entry, set mute=0, load cnt=dur, go to PLAY.
- PLAY: each `sample_req` decrements cnt.
  - A `sample_req` seen with cnt==1 ends the step.
  - If idx==DEPTH-1, the next idx is 0 when `loop_en`=1; otherwise the program ends (pulse `done`, go to IDLE).
  - Otherwise the next idx is idx+1.
  - Next state is GAP when the macro is defined, else LOAD.
- `stop` has priority over everything. From any state, the next state is IDLE with no `done` pulse. `stop` and `start` in the same cycle leaves the block in IDLE.
- `loop_en` is sampled at the moment of the wrap decision, not latched at `start`.
- Arithmetic: cnt is DUR_W bits, unsigned, and never decrements below 1 in PLAY. idx wraps modulo DEPTH.
- Outputs in IDLE: wave_sel=0, amp_ctrl=0, freq_sel=0, mute=1, step_idx=0.

## Timing
- Reset values: all outputs 0 except mute=1. State=IDLE, cnt=0, idx=0.
- Latency from `start` (cycle T) to the first entry's outputs: LOAD at T+1, outputs and mute=0 valid at T+2.
- Step length: an entry with dur=D is active for exactly D `sample_req` pulses, counted from the first pulse after its outputs go valid.
- A `sample_req` during a LOAD cycle is not counted.
- From the ending `sample_req` at cycle S (no gap):
  - LOAD at S+1.
  - New outputs at S+2.
  - Program end: IDLE and the `done` pulse at S+2.
- `done` is high for exactly one cycle, coincident with the first IDLE cycle.
- Reset asserted mid-step: all outputs go to reset values immediately (asynchronously). The table contents are retained.
- `busy` deasserts in the same cycle that the outputs return to their IDLE values.

## Configuration
- `WAVE_SCHED_GAP_EN` defined:
  - After each non-final step, GAP holds mute=1 with the previous wave/amp/freq values.
  - GAP lasts until the next `sample_req`, then goes to LOAD. The result is a one-sample silence between steps for audible articulation.
  - No GAP state is entered after the final step.
- `WAVE_SCHED_GAP_EN` undefined: the GAP state and its logic are absent, and steps are back-to-back with mute=0 throughout playback.

## Test plan
- Program entries 0..2 with durations {3,5,2} and entry 3 dur=0; `start` with loop_en=0 and `sample_req` every 8 cycles.
  - Outputs change after pulses 3 and 8; `done` pulses after pulse 10.
  - mute returns to 1 and busy to 0.
- Same program with loop_en=1:
  - After entry 2 ends, step_idx returns to 0.
  - Entry 0's values reappear at S+3: LOAD of entry 3, LOAD of entry 0, then outputs. No `done` pulse.
- `stop` during PLAY of entry 1 with cnt=4:
  - IDLE next cycle with all outputs 0 and mute=1; `done` never asserts.
  - A following `start` restarts at entry 0.
- Assert reset_n low mid-step, then release:
  - Outputs are at reset values asynchronously.
  - A following `start` replays the unchanged table.
- Rewrite the active entry 1 (dur 5 -> 2) during its PLAY: the current step still lasts 5 samples, and the next loop pass lasts 2.
- With `WAVE_SCHED_GAP_EN` defined, entries with durations {2,2}: mute=1 for exactly one sample between the steps, and no gap after the last step before `done`.
